// File: rtl/sap_loader.sv
// Serial program loader for a 16x8 program RAM: streams bytes into RAM, then releases the CPU.
// Optional trailing checksum byte is enabled with the LOADER_CHECKSUM_EN macro.
module sap_loader (
  input  logic       clk,
  input  logic       low_clr,
  input  logic       start,
  input  logic       stop,
  input  logic       in_valid,
  input  logic [7:0] in_data,
  output logic       in_ready,
  output logic [3:0] ram_addr,
  output logic [7:0] ram_data,
  output logic       low_ram_we,
  output logic       cpu_clr,
  output logic       done,
  output logic       err
);

`ifdef LOADER_CHECKSUM_EN
  typedef enum logic [2:0] {IDLE, LOAD, WRITE, CHECK, RUN, ERR} state_e;
`else
  typedef enum logic [2:0] {IDLE, LOAD, WRITE, RUN} state_e;
`endif

  state_e     state_q, state_d;
  logic [3:0] addr_q, addr_d;
  logic [7:0] data_q, data_d;
  logic       hs;

  assign hs = in_valid & in_ready;

`ifdef LOADER_CHECKSUM_EN
  logic [7:0] sum_q, sum_d;
  logic [7:0] final_sum;

  assign final_sum = sum_q + in_data;

  always_ff @(posedge clk or negedge low_clr) begin
    if (!low_clr) sum_q <= 8'h00;
    else          sum_q <= sum_d;
  end
`endif

  always_ff @(posedge clk or negedge low_clr) begin
    if (!low_clr) begin
      state_q <= IDLE;
      addr_q  <= 4'h0;
      data_q  <= 8'h00;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
    end
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    data_d  = data_q;
`ifdef LOADER_CHECKSUM_EN
    sum_d   = sum_q;
`endif
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = LOAD;
          addr_d  = 4'h0;
`ifdef LOADER_CHECKSUM_EN
          sum_d   = 8'h00;
`endif
        end
      end
      LOAD: begin
        if (hs) begin
          data_d  = in_data;
          state_d = WRITE;
        end
      end
      WRITE: begin
`ifdef LOADER_CHECKSUM_EN
        sum_d = sum_q + data_q;
`endif
        // addr saturates at 15 so a 17th data byte can never reach RAM
        if (addr_q == 4'hF) begin
`ifdef LOADER_CHECKSUM_EN
          state_d = CHECK;
`else
          state_d = RUN;
`endif
        end else begin
          addr_d  = addr_q + 4'd1;
          state_d = LOAD;
        end
      end
`ifdef LOADER_CHECKSUM_EN
      CHECK: begin
        if (hs) state_d = (final_sum == 8'h00) ? RUN : ERR;
      end
      ERR: begin
        if (start) begin
          state_d = LOAD;
          addr_d  = 4'h0;
          sum_d   = 8'h00;
        end
      end
`endif
      RUN:     state_d = RUN;
      default: state_d = IDLE;
    endcase

    // stop overrides everything; the write already on the bus still completes
    if (stop) begin
      state_d = IDLE;
      addr_d  = addr_q;
      data_d  = data_q;
`ifdef LOADER_CHECKSUM_EN
      sum_d   = sum_q;
`endif
    end
  end

  always_comb begin
    in_ready   = 1'b0;
    low_ram_we = 1'b1;
    cpu_clr    = 1'b1;
    done       = 1'b0;
    err        = 1'b0;
    case (state_q)
      LOAD:  in_ready   = 1'b1;
      WRITE: low_ram_we = 1'b0;
      RUN: begin
        cpu_clr = 1'b0;
        done    = 1'b1;
      end
`ifdef LOADER_CHECKSUM_EN
      CHECK: in_ready = 1'b1;
      ERR:   err      = 1'b1;
`endif
      default: ;
    endcase
  end

  assign ram_addr = addr_q;
  assign ram_data = data_q;

endmodule

// File: tb/tb_sap_loader.sv
// Directed bench for sap_loader; exercises the checksum path when LOADER_CHECKSUM_EN is defined.
module tb_sap_loader;
  logic       clk;
  logic       low_clr;
  logic       start;
  logic       stop;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_ready;
  logic [3:0] ram_addr;
  logic [7:0] ram_data;
  logic       low_ram_we;
  logic       cpu_clr;
  logic       done;
  logic       err;

  int checks = 0;
  int passed = 0;
  int wr_count = 0;

  sap_loader dut (
    .clk        (clk),
    .low_clr    (low_clr),
    .start      (start),
    .stop       (stop),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .ram_addr   (ram_addr),
    .ram_data   (ram_data),
    .low_ram_we (low_ram_we),
    .cpu_clr    (cpu_clr),
    .done       (done),
    .err        (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (low_ram_we === 1'b0) wr_count++;
  end

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed 0x%02h expected 0x%02h", tag, obs, exp);
  endtask

  // Called with the DUT in LOAD, #1 after an edge; returns #1 after the gap edge.
  task automatic send_byte(input int idx, input logic [7:0] b);
    in_valid = 1'b1;
    in_data  = b;
    chk("ready_before_byte", {7'd0, in_ready}, 8'd1);
    @(posedge clk); #1;
    chk("we_low_in_write", {7'd0, low_ram_we}, 8'd0);
    chk("write_addr", {4'd0, ram_addr}, 8'(idx));
    chk("write_data", ram_data, b);
    $display("byte %0d: addr=%0d data=0x%02h", idx, ram_addr, ram_data);
    @(posedge clk); #1;
    chk("we_high_in_gap", {7'd0, low_ram_we}, 8'd1);
  endtask

  task automatic do_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic do_stop();
    in_valid = 1'b0;
    stop = 1'b1;
    @(posedge clk); #1;
    stop = 1'b0;
  endtask

  task automatic load16();
    for (int i = 0; i < 16; i++) send_byte(i, 8'(i + 1));
  endtask

  initial begin
    int n;
    int wr0;
    logic v;
    logic hs;
    logic [7:0] b;

    low_clr = 1'b0; start = 1'b0; stop = 1'b0; in_valid = 1'b0; in_data = 8'h00;
    #3;
    chk("rst_in_ready", {7'd0, in_ready}, 8'd0);
    chk("rst_we", {7'd0, low_ram_we}, 8'd1);
    chk("rst_addr", {4'd0, ram_addr}, 8'd0);
    chk("rst_data", ram_data, 8'd0);
    chk("rst_cpu_clr", {7'd0, cpu_clr}, 8'd1);
    chk("rst_done", {7'd0, done}, 8'd0);
    chk("rst_err", {7'd0, err}, 8'd0);
    #10 low_clr = 1'b1;

    // idle with stray in_valid: nothing consumed, nothing written
    in_valid = 1'b1; in_data = 8'hAA;
    for (int i = 0; i < 10; i++) @(posedge clk);
    #1;
    chk("idle_cpu_clr", {7'd0, cpu_clr}, 8'd1);
    chk("idle_in_ready", {7'd0, in_ready}, 8'd0);
    chk("idle_we", {7'd0, low_ram_we}, 8'd1);
    chk("idle_done", {7'd0, done}, 8'd0);
    chk("idle_no_writes", 8'(wr_count), 8'd0);
    in_valid = 1'b0;

    do_start();
    load16();
    in_valid = 1'b0;
    chk("load_write_count", 8'(wr_count), 8'd16);
`ifdef LOADER_CHECKSUM_EN
    chk("check_ready", {7'd0, in_ready}, 8'd1);
    chk("check_cpu_clr", {7'd0, cpu_clr}, 8'd1);
    in_valid = 1'b1; in_data = 8'h78;
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("cks_good_done", {7'd0, done}, 8'd1);
    chk("cks_good_cpu_clr", {7'd0, cpu_clr}, 8'd0);
    chk("cks_good_err", {7'd0, err}, 8'd0);
    chk("cks_not_written", 8'(wr_count), 8'd16);
`else
    chk("run_done", {7'd0, done}, 8'd1);
    chk("run_cpu_clr", {7'd0, cpu_clr}, 8'd0);
    chk("run_err", {7'd0, err}, 8'd0);
`endif
    chk("run_in_ready", {7'd0, in_ready}, 8'd0);
    do_start();
    chk("run_ignores_start", {7'd0, done}, 8'd1);
    do_stop();
    chk("stop_from_run_done", {7'd0, done}, 8'd0);
    chk("stop_from_run_cpu_clr", {7'd0, cpu_clr}, 8'd1);

`ifdef LOADER_CHECKSUM_EN
    do_start();
    load16();
    in_valid = 1'b1; in_data = 8'h77;
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("cks_bad_err", {7'd0, err}, 8'd1);
    chk("cks_bad_cpu_clr", {7'd0, cpu_clr}, 8'd1);
    chk("cks_bad_done", {7'd0, done}, 8'd0);
    do_start();
    chk("err_restart_ready", {7'd0, in_ready}, 8'd1);
    send_byte(0, 8'h3C);
    do_stop();
`endif

    // random in_valid during LOAD; at most 12 handshakes so the load never finishes
    do_start();
    n = 0;
    wr0 = wr_count;
    for (int c = 0; c < 24; c++) begin
      v = 1'($urandom_range(0, 1));
      in_valid = v;
      in_data = 8'($urandom);
      b = in_data;
      hs = v && in_ready;
      @(posedge clk); #1;
      if (hs) begin
        chk("rnd_we_low", {7'd0, low_ram_we}, 8'd0);
        chk("rnd_addr", {4'd0, ram_addr}, 8'(n));
        chk("rnd_data", ram_data, b);
        $display("rnd byte %0d: addr=%0d data=0x%02h", n, ram_addr, ram_data);
        n++;
      end else begin
        chk("rnd_we_high", {7'd0, low_ram_we}, 8'd1);
      end
    end
    in_valid = 1'b0;
    @(posedge clk); #1;
    chk("rnd_write_count", 8'(wr_count - wr0), 8'(n));
    do_stop();

    // stop during the WRITE at addr 5
    do_start();
    for (int i = 0; i < 5; i++) send_byte(i, 8'(8'h50 + i));
    in_valid = 1'b1; in_data = 8'h55;
    @(posedge clk); #1;
    stop = 1'b1;
    chk("stop_write_we", {7'd0, low_ram_we}, 8'd0);
    chk("stop_write_addr", {4'd0, ram_addr}, 8'd5);
    chk("stop_write_data", ram_data, 8'h55);
    @(posedge clk); #1;
    stop = 1'b0;
    in_valid = 1'b0;
    chk("stop_idle_ready", {7'd0, in_ready}, 8'd0);
    chk("stop_idle_we", {7'd0, low_ram_we}, 8'd1);
    chk("stop_idle_cpu_clr", {7'd0, cpu_clr}, 8'd1);
    chk("stop_addr_held", {4'd0, ram_addr}, 8'd5);
    @(posedge clk); #1;
    chk("stop_stays_idle", {7'd0, in_ready}, 8'd0);
    do_start();
    send_byte(0, 8'hA0);

    // async reset mid-cycle while waiting for the byte at addr 9
    for (int i = 1; i < 9; i++) send_byte(i, 8'(8'hB0 + i));
    chk("pre_rst_addr", {4'd0, ram_addr}, 8'd9);
    chk("pre_rst_ready", {7'd0, in_ready}, 8'd1);
    #3 low_clr = 1'b0;
    #1;
    chk("async_rst_ready", {7'd0, in_ready}, 8'd0);
    chk("async_rst_addr", {4'd0, ram_addr}, 8'd0);
    chk("async_rst_data", ram_data, 8'd0);
    chk("async_rst_we", {7'd0, low_ram_we}, 8'd1);
    chk("async_rst_cpu_clr", {7'd0, cpu_clr}, 8'd1);
    chk("async_rst_done", {7'd0, done}, 8'd0);
    chk("async_rst_err", {7'd0, err}, 8'd0);
    #2 low_clr = 1'b1;
    @(posedge clk); #1;
    chk("post_rst_idle", {7'd0, in_ready}, 8'd0);
    do_start();
    send_byte(0, 8'hC3);
    do_stop();

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule

// File: doc/sap_loader.md
SAP_LOADER -- requirements
Module: sap_loader

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset: clk (in, 1, rising-edge clock) and low_clr (in, 1, async active-low reset).
REQ-002 The block SHALL have the port start (in, 1): begin a program load; sampled in IDLE and ERR only.
REQ-003 The block SHALL have the port stop (in, 1): return to program mode from any state.
REQ-004 The block SHALL have the port in_valid (in, 1): in_data holds a byte.
REQ-005 The block SHALL have the port in_data (in, 8): program byte.
REQ-006 The block SHALL have the port in_ready (out, 1): the byte is accepted when in_valid and in_ready are both 1 on a clk edge.
REQ-007 The block SHALL have the port ram_addr (out, 4): 16x8 program RAM write address.
REQ-008 The block SHALL have the port ram_data (out, 8): RAM write data.
REQ-009 The block SHALL have the port low_ram_we (out, 1): RAM write enable, active-low.
REQ-010 The block SHALL have the port cpu_clr (out, 1): drives the control sequencer clr; 1 holds the CPU in reset.
REQ-011 The block SHALL have the ports done (out, 1): load complete, CPU running; and err (out, 1): checksum failure.

Function
REQ-012 The block SHALL be a Moore FSM with states IDLE, LOAD, WRITE, CHECK, RUN, ERR; in_ready, low_ram_we, cpu_clr, done and err SHALL decode from state only.
REQ-013 IDLE: in_ready=0, cpu_clr=1; start=1 -> LOAD with addr=0, sum=0.
REQ-014 LOAD: in_ready=1; on handshake, latch in_data into the data register -> WRITE.
REQ-015 WRITE (exactly 1 cycle): low_ram_we=0, ram_addr=addr, ram_data=latched byte; sum <= sum + byte (mod 256).
REQ-016 WRITE exit: if addr=15 -> CHECK when checksum is compiled in, else -> RUN; otherwise addr <= addr+1 -> LOAD.
REQ-017 Accepted-byte latency: handshake at edge N, byte written during cycle N+1, in_ready=1 again from cycle N+2; peak throughput 1 byte per 2 cycles.
REQ-018 CHECK: in_ready=1; on handshake, (sum + in_data) mod 256 = 0 -> RUN, else -> ERR; the checksum byte SHALL NOT be written to RAM.
REQ-019 RUN: cpu_clr=0, done=1, in_ready=0; start ignored; stop=1 -> IDLE.
REQ-020 ERR: err=1, cpu_clr=1; start=1 -> LOAD (addr=0, sum=0); stop=1 -> IDLE.
REQ-021 stop=1 SHALL force next state IDLE from every state and take priority over start and handshake; in WRITE the current write cycle still completes, and addr/sum are not advanced.
REQ-022 start while in LOAD, WRITE, CHECK or RUN SHALL be ignored.
REQ-023 in_valid while in_ready=0 SHALL be ignored; no byte is consumed.
REQ-024 addr SHALL be 4 bits and SHALL NOT wrap inside one load; a 17th data byte is never written.
REQ-025 low_ram_we SHALL be 0 only in WRITE and SHALL be glitch-free (registered state decode).
REQ-026 cpu_clr SHALL be 1 in every state except RUN.

Reset
REQ-027 low_clr=0 SHALL asynchronously force state=IDLE, addr=0, sum=0, data register=0.
REQ-028 During reset the outputs SHALL be: in_ready=0, low_ram_we=1, ram_addr=0, ram_data=0, cpu_clr=1, done=0, err=0.
REQ-029 Reset mid-load SHALL abandon the load; RAM contents already written are undefined for the next run.

Configuration
REQ-030 The macro LOADER_CHECKSUM_EN SHALL control the checksum feature.
REQ-031 With LOADER_CHECKSUM_EN defined, the CHECK state, sum accumulation and err SHALL be present, and a load SHALL take 17 bytes.
REQ-032 Without LOADER_CHECKSUM_EN, CHECK and ERR SHALL not exist, err SHALL be tied 0, and WRITE at addr=15 SHALL go directly to RUN after 16 bytes.

Verification
REQ-033 The bench SHALL cover: reset release with start=0 for 10 cycles -> cpu_clr=1, in_ready=0, low_ram_we=1, done=0.
REQ-034 The bench SHALL cover: start, then bytes 0x01..0x10 back-to-back with in_valid=1 -> 16 write pulses at ram_addr 0..15 with matching data, 1-cycle gaps between pulses.
REQ-035 The bench SHALL cover (CHECKSUM_EN): 16 bytes summing to 0x88, then checksum 0x78 -> RUN, done=1, cpu_clr=0; with checksum 0x77 instead -> err=1, cpu_clr=1, and start then restarts the load at addr 0.
REQ-036 The bench SHALL cover: in_valid toggled randomly during LOAD -> exactly one write per accepted byte; no writes without a handshake.
REQ-037 The bench SHALL cover: stop asserted in the WRITE at addr=5 -> that write occurs, next state IDLE, and a subsequent start writes from addr 0.
REQ-038 The bench SHALL cover: low_clr pulsed low mid-clock during LOAD at addr=9 -> outputs reset immediately without waiting for clk; start resumes at addr 0.
